acc_shifter: RTL and testbench



---
 rtl/acc_shifter_pkg.sv | 22 ++
 rtl/acc_shifter_piso32.sv | 27 ++
 rtl/acc_shifter.sv | 108 ++++++++++
 tb/tb_acc_shifter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/acc_shifter_pkg.sv
// Shared types and constants for the accumulator read-out serializer.
package acc_shifter_pkg;

   localparam int unsigned WORD_W   = 32;
   localparam logic        SHT_KEEP = 1'b0;
   localparam logic        SHT_ZERO = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_SHIFT
   } state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(value)) r++;
      return r;
   endfunction

endpackage

// File: rtl/acc_shifter_piso32.sv
// Parallel-load, right-shift register; bit 0 is the serial output.
module piso32
   import acc_shifter_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] din,
   output logic              dout
);

   logic [WORD_W-1:0] shreg;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         shreg <= '0;
      end else if (load) begin
         shreg <= din;
      end else if (shift) begin
         shreg <= {1'b0, shreg[WORD_W-1:1]};
      end
   end

   assign dout = shreg[0];

endmodule

// File: rtl/acc_shifter.sv
// Walks img_size+1 SRAM words from start_addr and streams each one LSB-first,
// or streams the same number of zero words without reading the SRAM.
module acc_shifter
   import acc_shifter_pkg::*;
#(
   parameter  int unsigned SRAM_DEPTH = 1024,
   localparam int unsigned AW         = clog2(SRAM_DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic              sram_en,
   output logic [AW-1:0]     sram_addr,
   input  logic [WORD_W-1:0] sram_data,
   input  logic              shift_start,
   output logic              shift_idle,
   input  logic              shift_ctrl,
   input  logic [AW-1:0]     start_addr,
   input  logic [AW-1:0]     img_size,
   output logic              serial_output,
   output logic              serial_start,
   output logic              serial_en
);

   localparam int unsigned BW = clog2(WORD_W);

   state_t          state, state_nxt;
   logic            ctrl_q;
   logic [AW-1:0]   base_q, size_q, word_cnt;
   logic [BW-1:0]   bit_cnt;
   logic            last_bit, last_word, shreg_bit;

   assign last_bit  = (bit_cnt == BW'(WORD_W - 1));
   assign last_word = (word_cnt == size_q);

   always_ff @(posedge clk) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (shift_start) state_nxt = ST_READ;
         ST_READ:  state_nxt = ST_WAIT;
         ST_WAIT:  state_nxt = ST_SHIFT;
         ST_SHIFT: if (last_bit) state_nxt = last_word ? ST_IDLE : ST_READ;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ctrl_q   <= SHT_KEEP;
         base_q   <= '0;
         size_q   <= '0;
         word_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: if (shift_start) begin
               ctrl_q   <= shift_ctrl;
               base_q   <= start_addr;
               size_q   <= img_size;
               word_cnt <= '0;
               bit_cnt  <= '0;
            end
            ST_SHIFT: begin
               // bit_cnt wraps to 0 after the last bit, ready for the next word
               bit_cnt <= bit_cnt + 1'b1;
               if (last_bit && !last_word) word_cnt <= word_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      shift_idle    = 1'b0;
      sram_en       = 1'b0;
      sram_addr     = '0;
      serial_en     = 1'b0;
      serial_start  = 1'b0;
      serial_output = 1'b0;
      case (state)
         ST_IDLE: shift_idle = 1'b1;
         ST_READ: if (ctrl_q == SHT_KEEP) begin
            sram_en   = 1'b1;
            sram_addr = base_q + word_cnt;
         end
         ST_SHIFT: begin
            serial_en     = 1'b1;
            serial_start  = (bit_cnt == '0);
            serial_output = shreg_bit;
         end
         default: ;
      endcase
   end

   piso32 u_piso (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (state == ST_WAIT),
      .shift   (state == ST_SHIFT),
      .din     ((ctrl_q == SHT_ZERO) ? '0 : sram_data),
      .dout    (shreg_bit)
   );

endmodule

// File: tb/tb_acc_shifter.sv
// Directed self-checking bench for acc_shifter with a behavioural SRAM.
module tb_acc_shifter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sram_en;
   logic [9:0]  sram_addr;
   logic [31:0] sram_data = '0;
   logic        shift_start = 1'b0;
   logic        shift_idle;
   logic        shift_ctrl = 1'b0;
   logic [9:0]  start_addr = '0;
   logic [9:0]  img_size = '0;
   logic        serial_output, serial_start, serial_en;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [1024];
   logic [31:0] words [$];
   logic [31:0] exp_q [$];
   logic [31:0] cur = '0;
   int bi = 0, start_cnt = 0, en_cnt = 0, sram_en_cnt = 0, anomaly = 0;
   int cyc;

   always #5 clk = ~clk;

   acc_shifter #(.SRAM_DEPTH(1024)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .sram_en       (sram_en),
      .sram_addr     (sram_addr),
      .sram_data     (sram_data),
      .shift_start   (shift_start),
      .shift_idle    (shift_idle),
      .shift_ctrl    (shift_ctrl),
      .start_addr    (start_addr),
      .img_size      (img_size),
      .serial_output (serial_output),
      .serial_start  (serial_start),
      .serial_en     (serial_en)
   );

   always @(posedge clk) if (sram_en) sram_data <= mem[sram_addr];

   // Serial-bus monitor: reassembles words and records framing anomalies.
   always @(negedge clk) begin
      if (sram_en) sram_en_cnt++;
      if (serial_start) begin
         start_cnt++;
         if (!serial_en || bi != 0) anomaly++;
      end
      if (serial_en) begin
         en_cnt++;
         cur[bi[4:0]] = serial_output;
         bi++;
         if (bi == 32) begin
            words.push_back(cur);
            bi = 0;
         end
      end else if (serial_output) begin
         anomaly++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      words.delete();
      bi = 0; start_cnt = 0; en_cnt = 0; sram_en_cnt = 0; anomaly = 0;
   endtask

   task automatic do_run(input logic ctrl, input logic [9:0] addr, input logic [9:0] size,
                         input int pulse_at, output int cycles);
      clear_mon();
      @(negedge clk);
      shift_ctrl = ctrl; start_addr = addr; img_size = size; shift_start = 1'b1;
      @(posedge clk); #1;
      shift_start = 1'b0;
      shift_ctrl = ~ctrl; start_addr = addr + 10'd5; img_size = size + 10'd3;
      check("idle_drop", {31'b0, shift_idle}, 32'd0);
      cycles = 0;
      while (cycles < 5000) begin
         @(posedge clk); #1;
         cycles++;
         shift_start = (cycles == pulse_at);
         if (shift_idle) break;
      end
      shift_start = 1'b0;
   endtask

   task automatic check_stream(input string tag, input int n);
      check({tag, "_nwords"}, words.size(), n);
      for (int i = 0; i < n && i < words.size(); i++)
         check($sformatf("%s_word%0d", tag, i), words[i], exp_q[i]);
      check({tag, "_starts"}, start_cnt, n);
      check({tag, "_en_cycles"}, en_cnt, 32 * n);
      check({tag, "_framing"}, anomaly, 0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hFFFF_0000 | i;
      for (int i = 0; i < 10; i++) mem[i] = i;

      repeat (3) @(posedge clk);
      #1;
      check("rst_idle", {31'b0, shift_idle}, 32'd1);
      check("rst_sram_en", {31'b0, sram_en}, 32'd0);
      check("rst_addr", {22'b0, sram_addr}, 32'd0);
      check("rst_serial", {29'b0, serial_output, serial_start, serial_en}, 32'd0);
      @(negedge clk); reset_n = 1'b1;

      // SRAM words 0..9 streamed LSB-first
      exp_q.delete();
      for (int i = 0; i < 10; i++) exp_q.push_back(i);
      do_run(1'b0, 10'd0, 10'd9, 0, cyc);
      check("keep_len", cyc, 340);
      check("keep_sram_reads", sram_en_cnt, 10);
      check_stream("keep", 10);

      // zero mode: same length, no SRAM access
      exp_q.delete();
      for (int i = 0; i < 10; i++) exp_q.push_back(32'h0);
      do_run(1'b1, 10'd0, 10'd9, 0, cyc);
      check("zero_len", cyc, 340);
      check("zero_sram_reads", sram_en_cnt, 0);
      check_stream("zero", 10);

      // address wrap 1022 -> 1023 -> 0 -> 1
      mem[1022] = 32'hA5A5_A5A5; mem[1023] = 32'hDEAD_BEEF;
      mem[0] = 32'h1; mem[1] = 32'h8000_0000;
      exp_q.delete();
      exp_q.push_back(32'hA5A5_A5A5); exp_q.push_back(32'hDEAD_BEEF);
      exp_q.push_back(32'h1); exp_q.push_back(32'h8000_0000);
      do_run(1'b0, 10'd1022, 10'd3, 0, cyc);
      check("wrap_len", cyc, 136);
      check_stream("wrap", 4);
      mem[0] = 32'h0; mem[1] = 32'h1;

      // start pulse mid-run is ignored
      exp_q.delete();
      for (int i = 0; i < 10; i++) exp_q.push_back(i);
      do_run(1'b0, 10'd0, 10'd9, 100, cyc);
      check("pulse_len", cyc, 340);
      check_stream("pulse", 10);

      // single word with img_size = 0
      exp_q.delete();
      exp_q.push_back(32'h5);
      do_run(1'b0, 10'd5, 10'd0, 0, cyc);
      check("one_len", cyc, 34);
      check_stream("one", 1);

      // reset mid-word aborts the stream
      clear_mon();
      @(negedge clk);
      shift_ctrl = 1'b0; start_addr = 10'd0; img_size = 10'd9; shift_start = 1'b1;
      @(negedge clk); shift_start = 1'b0;
      repeat (50) @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk); #1;
      check("abort_idle", {31'b0, shift_idle}, 32'd1);
      check("abort_sram", {21'b0, sram_en, sram_addr}, 32'd0);
      check("abort_serial", {29'b0, serial_output, serial_start, serial_en}, 32'd0);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      check("abort_stays_idle", {31'b0, shift_idle}, 32'd1);

      exp_q.delete();
      for (int i = 0; i < 10; i++) exp_q.push_back(i);
      do_run(1'b0, 10'd0, 10'd9, 0, cyc);
      check("after_rst_len", cyc, 340);
      check_stream("after_rst", 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
